// File: rtl/clb_cfg_loader.sv
// rtl/clb_cfg_loader.sv - framed serial bitstream to per-CLB configuration word loader
module clb_cfg_loader #(
    parameter int NUM_CLB = 4,
    parameter int ADDR_W  = 2,
    parameter int CFG_W   = 37
) (
    input  logic              K,
    input  logic              RST_N,
    input  logic              DIN,
    input  logic              DVALID,
    output logic [CFG_W-1:0]  CFG_DATA,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic              CFG_WE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [7:0]        ERR_CNT
);
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CFG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CLB - 1);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        PAYLOAD = 3'd1,
        PARITY  = 3'd2,
        STOP    = 3'd3,
        DONE_S  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_win;
    logic [CFG_W-1:0]   r_stage;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_par_ok;
    logic               r_we;
    logic               r_err;
    logic [7:0]         r_err_cnt;
    logic [CFG_W-1:0]   r_data;
    logic [ADDR_W-1:0]  r_idx;

    logic [3:0]         w_win_nxt;
    logic               w_good;
    logic               w_last;

    assign w_win_nxt = {r_win[2:0], DIN};
    assign w_good    = r_par_ok & DIN;
    assign w_last    = (r_idx == LAST_IDX);

    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (DVALID) begin
            case (r_state)
                HUNT:    if (w_win_nxt == 4'b0010) w_next = PAYLOAD;
                PAYLOAD: if (r_cnt == LAST_BIT) w_next = PARITY;
                PARITY:  w_next = STOP;
                STOP:    w_next = (w_good && w_last) ? DONE_S : HUNT;
                DONE_S:  w_next = DONE_S;
                default: w_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            r_win     <= 4'b1111;
            r_stage   <= '0;
            r_cnt     <= '0;
            r_par_ok  <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
            r_data    <= '0;
            r_idx     <= '0;
        end else begin
            r_we <= 1'b0;
            // Index advances only once the write strobe has gone out with the old address.
            if (r_we && r_state != DONE_S) begin
                r_idx <= r_idx + 1'b1;
            end
            if (DVALID) begin
                case (r_state)
                    HUNT: begin
                        r_win <= w_win_nxt;
                        r_cnt <= '0;
                    end
                    PAYLOAD: begin
                        r_stage <= {r_stage[CFG_W-2:0], DIN};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    PARITY: begin
                        r_par_ok <= ~(^{r_stage, DIN});
                    end
                    STOP: begin
                        // Fresh window so a new preamble never borrows bits from this frame.
                        r_win <= 4'b1111;
                        if (w_good) begin
                            r_data <= r_stage;
                            r_we   <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign CFG_DATA = r_data;
    assign CFG_ADDR = r_idx;
    assign CFG_WE   = r_we;
    assign BUSY     = (r_state == PAYLOAD) || (r_state == PARITY) || (r_state == STOP);
    assign DONE     = (r_state == DONE_S);
    assign ERR      = r_err;
    assign ERR_CNT  = r_err_cnt;
endmodule
